matrix_stream_generator: RTL and testbench

//  Upstream stimulus source for the HLS matrix multiplier; emits operand matrices A then B on the

---
 rtl/matrix_stream_generator.sv | 167 ++++++++++++++++
 tb/tb_matrix_stream_generator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_generator.sv
// Operand stream source for the HLS matrix multiplier.
// Emits A (ramp) then B (scaled identity) as one AXI4-Stream frame of 2*DIM*DIM words,
// paced by a start delay after reset and an inter-frame gap; counts frames and flags completion.
module matrix_stream_generator #(
  parameter int unsigned DIM               = 6,
  parameter logic [31:0] A_BASE            = 32'd1,
  parameter logic [31:0] B_DIAG            = 32'd2,
  parameter logic [19:0] Start_Delay_Value = 20'd100,
  parameter logic [7:0]  Gap_Value         = 8'd4,
  parameter logic [7:0]  NUM_FRAMES        = 8'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        input_r_TREADY_0,
  output logic        input_r_TVALID_0,
  output logic [31:0] input_r_TDATA_0,
  output logic        input_r_TLAST_0,
  output logic [7:0]  Frame_Counter,
  output logic        Done
);

  localparam int unsigned WORDS = DIM * DIM;
  localparam int unsigned KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned RW    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [KW-1:0] K_LAST  = KW'(WORDS - 1);
  localparam logic [RW-1:0] RC_LAST = RW'(DIM - 1);
  // With a 1x1 matrix the first B word is also the last word of the frame.
  localparam logic FIRST_B_LAST = (WORDS == 1);

  typedef enum logic [2:0] {
    S_WAIT,
    S_SEND_A,
    S_SEND_B,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state;
  logic [19:0]   dly_cnt;
  logic [KW-1:0] k_cnt;
  logic [RW-1:0] row;
  logic [RW-1:0] col;
  logic [7:0]    gap_cnt;

  logic          hs;
  logic          wait_done;
  logic          gap_done;
  logic [7:0]    fc_next;
  logic [RW-1:0] row_n;
  logic [RW-1:0] col_n;
  logic          b_last_n;

  // Handshake, pacing terminal counts and next B-matrix position.
  always_comb begin
    hs        = input_r_TVALID_0 & input_r_TREADY_0;
    wait_done = (Start_Delay_Value == '0) || (dly_cnt == Start_Delay_Value - 20'd1);
    gap_done  = (gap_cnt == Gap_Value - 8'd1);
    fc_next   = (Frame_Counter == 8'hFF) ? 8'hFF : Frame_Counter + 8'd1;
    if (col == RC_LAST) begin
      row_n = row + RW'(1);
      col_n = '0;
    end else begin
      row_n = row;
      col_n = col + RW'(1);
    end
    b_last_n = (row_n == RC_LAST) && (col_n == RC_LAST);
  end

  // Stream FSM with registered AXI4-Stream outputs and frame bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_WAIT;
      dly_cnt          <= '0;
      k_cnt            <= '0;
      row              <= '0;
      col              <= '0;
      gap_cnt          <= '0;
      input_r_TVALID_0 <= 1'b0;
      input_r_TDATA_0  <= '0;
      input_r_TLAST_0  <= 1'b0;
      Frame_Counter    <= '0;
      Done             <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (wait_done) begin
            state            <= S_SEND_A;
            dly_cnt          <= '0;
            k_cnt            <= '0;
            input_r_TVALID_0 <= 1'b1;
            input_r_TDATA_0  <= A_BASE;
            input_r_TLAST_0  <= 1'b0;
          end else begin
            dly_cnt <= dly_cnt + 20'd1;
          end
        end

        S_SEND_A: begin
          if (hs) begin
            if (k_cnt == K_LAST) begin
              state           <= S_SEND_B;
              k_cnt           <= '0;
              row             <= '0;
              col             <= '0;
              input_r_TDATA_0 <= B_DIAG;
              input_r_TLAST_0 <= FIRST_B_LAST;
            end else begin
              k_cnt           <= k_cnt + KW'(1);
              input_r_TDATA_0 <= input_r_TDATA_0 + 32'd1;
            end
          end
        end

        S_SEND_B: begin
          if (hs) begin
            if (input_r_TLAST_0) begin
              Frame_Counter   <= fc_next;
              input_r_TLAST_0 <= 1'b0;
              if ((NUM_FRAMES != '0) && (fc_next == NUM_FRAMES)) begin
                state            <= S_DONE;
                Done             <= 1'b1;
                input_r_TVALID_0 <= 1'b0;
              end else if (Gap_Value == '0) begin
                state            <= S_SEND_A;
                k_cnt            <= '0;
                input_r_TVALID_0 <= 1'b1;
                input_r_TDATA_0  <= A_BASE;
              end else begin
                state            <= S_GAP;
                gap_cnt          <= '0;
                input_r_TVALID_0 <= 1'b0;
              end
            end else begin
              row             <= row_n;
              col             <= col_n;
              input_r_TDATA_0 <= (row_n == col_n) ? B_DIAG : '0;
              input_r_TLAST_0 <= b_last_n;
            end
          end
        end

        S_GAP: begin
          if (gap_done) begin
            state            <= S_SEND_A;
            gap_cnt          <= '0;
            k_cnt            <= '0;
            input_r_TVALID_0 <= 1'b1;
            input_r_TDATA_0  <= A_BASE;
            input_r_TLAST_0  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        S_DONE: begin
          input_r_TVALID_0 <= 1'b0;
        end

        default: begin
          state            <= S_WAIT;
          input_r_TVALID_0 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_stream_generator.sv
// Randomised-TREADY bench for matrix_stream_generator: three differently parameterised
// instances are compared word by word against a frame model built from the stream's
// arithmetic definition, including pacing, frame counting, completion and mid-frame reset.
module tb_matrix_stream_generator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tready [3];
  logic        tv [3];
  logic [31:0] td [3];
  logic        tl [3];
  logic [7:0]  fc [3];
  logic        dn [3];

  // Model parameters, matching the instance overrides below.
  int unsigned p_dim  [3] = '{6, 6, 2};
  logic [31:0] p_abase[3] = '{32'd1, 32'd1, 32'hFFFF_FFFE};
  logic [31:0] p_bdiag[3] = '{32'd2, 32'd2, 32'h8000_0001};
  int unsigned p_sdv  [3] = '{100, 0, 3};
  int unsigned p_gap  [3] = '{4, 0, 1};
  int unsigned p_nf   [3] = '{3, 2, 0};

  int vectors = 0;
  int errors  = 0;

  bit mon_en   = 1'b0;
  bit rdy_mode = 1'b0;

  int          widx [3];
  int          frames [3];
  int          cyc [3];
  int          idle [3];
  int          vcyc [3];
  bit          started [3];
  bit          in_gap [3];
  bit          fr_pend [3];
  bit          done_exp [3];
  bit          prev_stall [3];
  logic [31:0] prev_d [3];
  logic        prev_l [3];

  always #5 clk = ~clk;

  matrix_stream_generator #(
    .DIM(6), .A_BASE(32'd1), .B_DIAG(32'd2),
    .Start_Delay_Value(20'd100), .Gap_Value(8'd4), .NUM_FRAMES(8'd3)
  ) u_dut0 (
    .clk(clk), .reset(reset), .input_r_TREADY_0(tready[0]),
    .input_r_TVALID_0(tv[0]), .input_r_TDATA_0(td[0]), .input_r_TLAST_0(tl[0]),
    .Frame_Counter(fc[0]), .Done(dn[0])
  );

  matrix_stream_generator #(
    .DIM(6), .A_BASE(32'd1), .B_DIAG(32'd2),
    .Start_Delay_Value(20'd0), .Gap_Value(8'd0), .NUM_FRAMES(8'd2)
  ) u_dut1 (
    .clk(clk), .reset(reset), .input_r_TREADY_0(tready[1]),
    .input_r_TVALID_0(tv[1]), .input_r_TDATA_0(td[1]), .input_r_TLAST_0(tl[1]),
    .Frame_Counter(fc[1]), .Done(dn[1])
  );

  matrix_stream_generator #(
    .DIM(2), .A_BASE(32'hFFFF_FFFE), .B_DIAG(32'h8000_0001),
    .Start_Delay_Value(20'd3), .Gap_Value(8'd1), .NUM_FRAMES(8'd0)
  ) u_dut2 (
    .clk(clk), .reset(reset), .input_r_TREADY_0(tready[2]),
    .input_r_TVALID_0(tv[2]), .input_r_TDATA_0(td[2]), .input_r_TLAST_0(tl[2]),
    .Frame_Counter(fc[2]), .Done(dn[2])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Word w of a frame: A in row-major order, then B = B_DIAG * identity.
  function automatic logic [31:0] exp_word(input int i, input int w);
    int n, r, c;
    n = p_dim[i] * p_dim[i];
    if (w < n) return p_abase[i] + 32'(w);
    r = (w - n) / p_dim[i];
    c = (w - n) % p_dim[i];
    return (r == c) ? p_bdiag[i] : 32'd0;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      widx[i] = 0; frames[i] = 0; cyc[i] = 0; idle[i] = 0; vcyc[i] = 0;
      started[i] = 0; in_gap[i] = 0; fr_pend[i] = 0; done_exp[i] = 0;
      prev_stall[i] = 0; prev_d[i] = '0; prev_l[i] = 0;
    end
  endtask

  task automatic mon_step(input int i);
    int  n2;
    int  sat;
    bit  exp_done;
    bit  handled;
    n2 = 2 * p_dim[i] * p_dim[i];
    cyc[i]++;
    handled = 0;
    if (done_exp[i]) begin
      check_val($sformatf("idle_after_done%0d", i), tv[i], 1'b0);
      handled = 1;
    end else if (fr_pend[i]) begin
      fr_pend[i] = 0;
      sat = (frames[i] > 255) ? 255 : frames[i];
      check_val($sformatf("frame_cnt%0d", i), fc[i], 32'(sat));
      exp_done = (p_nf[i] != 0) && (frames[i] >= int'(p_nf[i]));
      check_val($sformatf("done%0d", i), dn[i], exp_done);
      if (exp_done) begin
        done_exp[i] = 1;
        check_val($sformatf("valid_at_done%0d", i), tv[i], 1'b0);
        handled = 1;
      end else begin
        in_gap[i] = 1;
        idle[i]   = 0;
      end
    end
    if (!handled) begin
      if (prev_stall[i]) begin
        check_val($sformatf("hold_valid%0d", i), tv[i], 1'b1);
        check_val($sformatf("hold_data%0d", i), td[i], prev_d[i]);
        check_val($sformatf("hold_last%0d", i), tl[i], prev_l[i]);
      end
      if (!started[i] && tv[i]) begin
        started[i] = 1;
        check_val($sformatf("start_delay%0d", i), cyc[i], (p_sdv[i] == 0) ? 32'd1 : p_sdv[i]);
      end
      if (tv[i]) begin
        if (in_gap[i]) begin
          check_val($sformatf("gap_len%0d", i), idle[i], p_gap[i]);
          in_gap[i] = 0;
        end
        vcyc[i]++;
        if (tready[i]) begin
          check_val($sformatf("data%0d_w%0d", i, widx[i]), td[i], exp_word(i, widx[i]));
          check_val($sformatf("last%0d_w%0d", i, widx[i]), tl[i], widx[i] == n2 - 1);
          widx[i]++;
          if (widx[i] == n2) begin
            widx[i] = 0;
            frames[i]++;
            fr_pend[i] = 1;
          end
        end
      end else if (in_gap[i]) begin
        idle[i]++;
      end
    end
    prev_stall[i] = !done_exp[i] && tv[i] && !tready[i];
    prev_d[i]     = td[i];
    prev_l[i]     = tl[i];
  endtask

  // Per-cycle TREADY choice for the coming edge, then model step for each instance.
  initial begin
    for (int i = 0; i < 3; i++) tready[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) tready[i] = rdy_mode ? 1'b1 : 1'($urandom_range(0, 1));
      if (mon_en) for (int i = 0; i < 3; i++) mon_step(i);
    end
  end

  task automatic release_reset();
    @(negedge clk);
    #2;
    reset_model();
    reset  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    reset  = 1'b0;
    mon_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset_model();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("rst_valid%0d", i), tv[i], 1'b0);
      check_val($sformatf("rst_data%0d", i), td[i], 32'd0);
      check_val($sformatf("rst_last%0d", i), tl[i], 1'b0);
      check_val($sformatf("rst_fc%0d", i), fc[i], 8'd0);
      check_val($sformatf("rst_done%0d", i), dn[i], 1'b0);
    end

    // Random backpressure: all frames, gaps, completion and counter saturation.
    release_reset();
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      #2;
      if (done_exp[0] && done_exp[1] && frames[2] >= 300) break;
    end
    check_val("end_done0", dn[0], 1'b1);
    check_val("end_fc0", fc[0], 8'd3);
    check_val("end_done1", dn[1], 1'b1);
    check_val("end_fc1", fc[1], 8'd2);
    check_val("sat_fc2", fc[2], 8'hFF);
    check_val("sat_done2", dn[2], 1'b0);

    // TREADY held high: back-to-back frames give unbroken TVALID.
    pulse_reset();
    rdy_mode = 1'b1;
    release_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #2;
      if (done_exp[0] && done_exp[1]) break;
    end
    check_val("full_rate_valid1", vcyc[1], 32'd144);
    check_val("full_rate_valid0", vcyc[0], 32'd216);
    check_val("full_rate_done1", dn[1], 1'b1);

    // Reset asserted mid-frame, then full restart from the start delay.
    pulse_reset();
    rdy_mode = 1'b0;
    release_reset();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      #2;
      if (widx[0] >= 40) break;
    end
    check_val("pre_reset_valid0", tv[0], 1'b1);
    reset  = 1'b0;
    mon_en = 1'b0;
    #1;
    check_val("async_valid0", tv[0], 1'b0);
    check_val("async_data0", td[0], 32'd0);
    check_val("async_fc0", fc[0], 8'd0);
    repeat (2) @(negedge clk);
    release_reset();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      #2;
      if (frames[0] >= 1 && !fr_pend[0]) break;
    end
    check_val("restart_fc0", fc[0], 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
